// File: rtl/hilo_unit.sv
// HI/LO register stage wrapped around an external combinational multiplier.
// Optional macro HILO_BYPASS_EN forwards the multiplier result to rdata in the completion cycle.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] mul_opA,
  output logic [WIDTH-1:0] mul_opB,
  output logic             mul_op,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  logic [0:0]       r_state;
  logic [3:0]       r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_op;
  logic             r_done;

  logic w_busy;
  logic w_last;

  assign w_busy = (r_state == S_BUSY);
  // Completion cycle: the capture edge closes this cycle.
  assign w_last = w_busy && (r_count == 4'd1);

  // NOTE: reset is sampled on the clock edge only, so it lives inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_op    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of the others, independent of statement order.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_opa   <= opA;
            r_opb   <= opB;
            r_op    <= op;
            r_count <= LAT;
            r_state <= S_BUSY;
          end
        end
        default: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_hi    <= mul_hi;
            r_lo    <= mul_lo;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mul_opA = r_opa;
  assign mul_opB = r_opb;
  assign mul_op  = r_op;
  assign busy    = w_busy;
  assign done    = r_done;

`ifdef HILO_BYPASS_EN
  always_comb begin
    if (w_last) rdata = rd_sel ? mul_hi : mul_lo;
    else        rdata = rd_sel ? r_hi : r_lo;
  end

  assign stall = w_busy & (start | mthi | mtlo | (rd_en & ~w_last));
`else
  always_comb begin
    rdata = rd_sel ? r_hi : r_lo;
  end

  assign stall = w_busy & (start | rd_en | mthi | mtlo);
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus pushes expected results, a negedge
// monitor pops them on every done pulse and every serviced read.
module tb_hilo_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, op, mthi, mtlo, rd_en, rd_sel;
  logic [W-1:0] opA, opB, wdata;
  logic [W-1:0] mul_opA, mul_opB, mul_hi, mul_lo, rdata;
  logic         mul_op, busy, done, stall;
  logic [63:0]  w_prod;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] done_q[$];
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .opA(opA), .opB(opB),
    .mul_opA(mul_opA), .mul_opB(mul_opB), .mul_op(mul_op),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .rd_en(rd_en), .rd_sel(rd_sel), .rdata(rdata),
    .busy(busy), .done(done), .stall(stall)
  );

  // Environment model of the combinational multiplier.
  always_comb begin
    if (mul_op)
      w_prod = 64'($signed({{32{mul_opA[31]}}, mul_opA}) * $signed({{32{mul_opB[31]}}, mul_opB}));
    else
      w_prod = {32'd0, mul_opA} * {32'd0, mul_opB};
  end
  assign mul_hi = w_prod[63:32];
  assign mul_lo = w_prod[31:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("done_expected", 64'(done_q.size() > 0), 64'd1);
      if (done_q.size() > 0) check("product_at_done", {mul_hi, mul_lo}, done_q.pop_front());
    end
    if (rd_en && !stall) begin
      check("read_expected", 64'(rd_q.size() > 0), 64'd1);
      if (rd_q.size() > 0) check("rdata", 64'(rdata), 64'(rd_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles until the current request is serviced (bounded).
  task automatic wait_nostall(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 50) begin
        n_vec++; n_err++;
        $display("FAIL stall_timeout: stall still high after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done) break;
      if (n > 50) begin
        n_vec++; n_err++;
        $display("FAIL done_timeout: no done after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic issue_mul(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input logic push);
    int n;
    op = s; opA = a; opB = b; start = 1'b1;
    if (push) done_q.push_back(exp);
    wait_nostall(n);
    tick();
    start = 1'b0;
  endtask

  task automatic do_read(input logic sel, input logic [31:0] exp, output int n);
    rd_q.push_back(exp);
    rd_sel = sel; rd_en = 1'b1;
    wait_nostall(n);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0; start = 1'b1; op = 1'b1; opA = 32'hDEAD; opB = 32'hBEEF;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_en = 1'b0; rd_sel = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_opA", 64'(mul_opA), 64'd0);
    check("rst_opB", 64'(mul_opB), 64'd0);
    check("rst_op", 64'(mul_op), 64'd0);
    tick();
    start = 1'b0; resetn = 1'b1;
    do_read(1'b1, 32'h0, n);
    do_read(1'b0, 32'h0, n);

    // Unsigned max, with done latency and pulse width
    issue_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_done(n);
    check("done_latency", 64'(n), 64'(LAT + 1));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    tick();
    do_read(1'b1, 32'hFFFF_FFFE, n);
    do_read(1'b0, 32'h0000_0001, n);

    // Signed
    issue_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
    wait_done(n); tick();
    do_read(1'b1, 32'h0000_0000, n);
    do_read(1'b0, 32'h0000_0001, n);
    issue_mul(1'b1, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000, 1'b1);
    wait_done(n); tick();
    do_read(1'b1, 32'hFFFF_FFFF, n);
    do_read(1'b0, 32'h0000_0000, n);

    // Read held during a multiply
    issue_mul(1'b0, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000, 1'b1);
    do_read(1'b1, 32'h0000_0003, n);
`ifdef HILO_BYPASS_EN
    check("read_stall_cycles", 64'(n), 64'd1);
`else
    check("read_stall_cycles", 64'(n), 64'(LAT));
`endif
    repeat (3) tick();

    // MTHI / MTLO in IDLE
    wdata = 32'h1234_5678; mthi = 1'b1;
    @(negedge clk); check("mthi_stall", 64'(stall), 64'd0);
    tick(); mthi = 1'b0;
    wdata = 32'h9ABC_DEF0; mtlo = 1'b1;
    @(negedge clk); check("mtlo_stall", 64'(stall), 64'd0);
    tick(); mtlo = 1'b0;
    do_read(1'b1, 32'h1234_5678, n);
    check("mt_read_hi_stall", 64'(n), 64'd0);
    do_read(1'b0, 32'h9ABC_DEF0, n);
    check("mt_read_lo_stall", 64'(n), 64'd0);

    // Reset lands mid-multiply
    issue_mul(1'b0, 32'd3, 32'd5, 64'd15, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_opA", 64'(mul_opA), 64'd0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n++;
    end
    check("midrst_no_done", 64'(n), 64'd0);
    tick();
    do_read(1'b1, 32'h0, n);
    do_read(1'b0, 32'h0, n);
    issue_mul(1'b0, 32'd7, 32'd6, 64'd42, 1'b1);
    wait_done(n); tick();
    do_read(1'b0, 32'd42, n);
    do_read(1'b1, 32'd0, n);

    // Back-to-back with start held
    issue_mul(1'b0, 32'd2, 32'd3, 64'd6, 1'b1);
    start = 1'b1; opA = 32'd4; opB = 32'd5;
    done_q.push_back(64'd20);
    wait_nostall(n);
    check("b2b_interim_stall", 64'(n), 64'(LAT));
    check("b2b_accept_after_done", 64'(done), 64'd1);
    tick();
    start = 1'b0;
    wait_done(n); tick();
    do_read(1'b0, 32'd20, n);
    do_read(1'b1, 32'd0, n);

    repeat (4) tick();
    check("done_queue_drained", 64'(done_q.size()), 64'd0);
    check("read_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
